// File: rtl/maxpool_layer.sv
// Streaming POOLxPOOL signed max-pooling over a raster-order feature map, CH channels in parallel.
// Define MAXPOOL_RELU_EN to clamp negative pooled results to zero.
module maxpool_layer #(
  parameter int DW   = 18,
  parameter int CH   = 2,
  parameter int IN_W = 24,
  parameter int IN_H = 24,
  parameter int POOL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strt,
  input  logic             tx_done,
  input  logic             din_vld,
  input  logic [CH*DW-1:0] din,
  output logic             bsy,
  output logic             dout_vld,
  output logic [CH*DW-1:0] dout,
  output logic             rdy
);

  localparam int NPC = IN_W / POOL;
  localparam int CW  = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int RW  = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int PW  = (NPC > 1) ? $clog2(NPC) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q;
  logic [CW-1:0]        col_q;
  logic [RW-1:0]        row_q;
  logic signed [DW-1:0] acc_q     [CH];
  logic signed [DW-1:0] lineBuf_q [NPC][CH];
  logic                 bsy_q;
  logic                 doutVld_q;
  logic                 rdy_q;
  logic [CH*DW-1:0]     dout_q;

  logic [PW-1:0]        pcIdx;
  logic                 colStart;
  logic                 colClose;
  logic                 winStart;
  logic                 winClose;
  logic                 lastCol;
  logic                 lastRow;
  logic signed [DW-1:0] pix     [CH];
  logic signed [DW-1:0] prior   [CH];
  logic signed [DW-1:0] newMax  [CH];
  logic signed [DW-1:0] poolOut [CH];

  // The first column of a window row continues from the line buffer; later columns from the accumulator.
  always_comb begin
    pcIdx    = PW'(int'(col_q) / POOL);
    colStart = (int'(col_q) % POOL) == 0;
    colClose = (int'(col_q) % POOL) == POOL - 1;
    winStart = colStart && ((int'(row_q) % POOL) == 0);
    winClose = colClose && ((int'(row_q) % POOL) == POOL - 1);
    lastCol  = (col_q == CW'(IN_W - 1));
    lastRow  = (row_q == RW'(IN_H - 1));
    for (int k = 0; k < CH; k++) begin
      pix[k]    = din[k*DW +: DW];
      prior[k]  = colStart ? lineBuf_q[pcIdx][k] : acc_q[k];
      newMax[k] = winStart ? pix[k] : ((pix[k] > prior[k]) ? pix[k] : prior[k]);
`ifdef MAXPOOL_RELU_EN
      poolOut[k] = newMax[k][DW-1] ? '0 : newMax[k];
`else
      poolOut[k] = newMax[k];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      bsy_q     <= 1'b0;
      doutVld_q <= 1'b0;
      rdy_q     <= 1'b0;
      dout_q    <= '0;
      for (int k = 0; k < CH; k++) begin
        acc_q[k] <= '0;
        for (int p = 0; p < NPC; p++) lineBuf_q[p][k] <= '0;
      end
    end else if (tx_done) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      bsy_q     <= 1'b0;
      doutVld_q <= 1'b0;
      rdy_q     <= 1'b0;
      for (int k = 0; k < CH; k++) begin
        acc_q[k] <= '0;
        for (int p = 0; p < NPC; p++) lineBuf_q[p][k] <= '0;
      end
    end else begin
      doutVld_q <= 1'b0;
      rdy_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (strt) begin
            state_q <= RUN;
            bsy_q   <= 1'b1;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        RUN: begin
          if (din_vld) begin
            for (int k = 0; k < CH; k++) begin
              acc_q[k] <= newMax[k];
              if (colClose) lineBuf_q[pcIdx][k] <= newMax[k];
              if (winClose) dout_q[k*DW +: DW] <= poolOut[k];
            end
            doutVld_q <= winClose;
            if (lastCol) begin
              col_q <= '0;
              if (lastRow) begin
                row_q   <= '0;
                state_q <= DONE;
                rdy_q   <= 1'b1;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          bsy_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          bsy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bsy      = bsy_q;
  assign dout_vld = doutVld_q;
  assign dout     = dout_q;
  assign rdy      = rdy_q;

endmodule

// File: tb/tb_maxpool_layer.sv
// Randomised and directed bench for maxpool_layer on a 4x4 single-channel map with 2x2 windows.
// Expected outputs come from a frame-array model that takes each window max directly.
module tb_maxpool_layer;
  localparam int DW   = 18;
  localparam int CH   = 1;
  localparam int IN_W = 4;
  localparam int IN_H = 4;
  localparam int POOL = 2;
  localparam int NPIX = IN_W * IN_H;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 strt;
  logic                 tx_done;
  logic                 din_vld;
  logic [CH*DW-1:0]     din;
  logic                 bsy;
  logic                 dout_vld;
  logic [CH*DW-1:0]     dout;
  logic                 rdy;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  logic signed [DW-1:0] frame [NPIX];
  int                   mState = 0;
  int                   mCnt = 0;
  int                   mr;
  int                   mc;
  bit                   expBsy;
  bit                   expVld;
  bit                   expRdy;
  logic signed [DW-1:0] expDout;
  logic signed [DW-1:0] obsQ [$];
  bit                   obsRdyQ [$];

  maxpool_layer #(
    .DW(DW), .CH(CH), .IN_W(IN_W), .IN_H(IN_H), .POOL(POOL)
  ) dut (
    .clk(clk), .rst(rst), .strt(strt), .tx_done(tx_done), .din_vld(din_vld), .din(din),
    .bsy(bsy), .dout_vld(dout_vld), .dout(dout), .rdy(rdy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [DW-1:0] windowMax(input int r0, input int c0);
    logic signed [DW-1:0] m;
    m = frame[r0*IN_W + c0];
    for (int dr = 0; dr < POOL; dr++)
      for (int dc = 0; dc < POOL; dc++)
        if (frame[(r0+dr)*IN_W + c0 + dc] > m) m = frame[(r0+dr)*IN_W + c0 + dc];
`ifdef MAXPOOL_RELU_EN
    if (m < 0) m = '0;
`endif
    return m;
  endfunction

  // Model: record accepted pixels and emit the window max when a window's last pixel lands.
  always @(posedge clk) begin
    expVld = 1'b0;
    expRdy = 1'b0;
    if (rst === 1'b1) begin
      mState  = 0;
      mCnt    = 0;
      expDout = '0;
    end else if (tx_done === 1'b1) begin
      mState = 0;
      mCnt   = 0;
    end else begin
      case (mState)
        0: if (strt === 1'b1) begin
          mState = 1;
          mCnt   = 0;
        end
        1: if (din_vld === 1'b1) begin
          frame[mCnt] = din;
          mr = mCnt / IN_W;
          mc = mCnt % IN_W;
          if ((mr % POOL == POOL - 1) && (mc % POOL == POOL - 1)) begin
            expDout = windowMax(mr - POOL + 1, mc - POOL + 1);
            expVld  = 1'b1;
          end
          mCnt++;
          if (mCnt == NPIX) begin
            mState = 2;
            expRdy = 1'b1;
          end
        end
        default: mState = 0;
      endcase
    end
    expBsy = (mState != 0);
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("bsy", bsy, expBsy);
      checkOutput("dout_vld", dout_vld, expVld);
      checkOutput("rdy", rdy, expRdy);
      checkOutput("dout", $signed(dout), expDout);
      if (dout_vld === 1'b1) begin
        obsQ.push_back($signed(dout));
        obsRdyQ.push_back(rdy);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (bsy !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) checkOutput("idle timeout", bsy, 0);
    step();
  endtask

  function automatic logic [DW-1:0] pixelValue(input int mode, input int i);
    logic signed [DW-1:0] v;
    case (mode)
      0:       v = DW'(i);
      1:       v = -3;
      default: v = DW'($urandom);
    endcase
    return v;
  endfunction

  // Drives one frame; gapMode 0 back-to-back, 1 alternating idle cycles, 2 random idle cycles.
  task automatic applyStimulus(input int mode, input int gapMode, input bit strtInRun);
    int gaps;
    obsQ.delete();
    obsRdyQ.delete();
    strt = 1'b1;
    step();
    strt = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      din_vld = 1'b1;
      din     = pixelValue(mode, i);
      if (strtInRun && (i == 6 || i == 11)) strt = 1'b1;
      step();
      strt    = 1'b0;
      din_vld = 1'b0;
      gaps = (gapMode == 0) ? 0 : (gapMode == 1) ? 1 : $urandom_range(0, 2);
      repeat (gaps) begin
        din = DW'($urandom);
        step();
      end
    end
    waitIdle();
  endtask

  task automatic checkFrame(input int exp[4]);
    checkOutput("out count", obsQ.size(), 4);
    if (obsQ.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("out[%0d]", i), obsQ[i], exp[i]);
        checkOutput($sformatf("rdy[%0d]", i), obsRdyQ[i], (i == 3) ? 1 : 0);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    strt    = 1'b0;
    tx_done = 1'b0;
    din_vld = 1'b0;
    din     = '0;
    step();
    step();
    checkEn = 1'b1;
    checkOutput("reset bsy", bsy, 0);
    checkOutput("reset dout_vld", dout_vld, 0);
    checkOutput("reset rdy", rdy, 0);
    checkOutput("reset dout", $signed(dout), 0);
    rst = 1'b0;
    step();

    applyStimulus(0, 0, 1'b0);
    checkFrame('{5, 7, 13, 15});

    applyStimulus(1, 0, 1'b0);
`ifdef MAXPOOL_RELU_EN
    checkFrame('{0, 0, 0, 0});
`else
    checkFrame('{-3, -3, -3, -3});
`endif

    applyStimulus(0, 1, 1'b1);
    checkFrame('{5, 7, 13, 15});

    // Abort partway through, then show that stray pixels are ignored until a fresh start.
    strt = 1'b1;
    step();
    strt = 1'b0;
    for (int i = 0; i < 7; i++) begin
      din_vld = 1'b1;
      din     = DW'(i + 100);
      step();
    end
    din_vld = 1'b0;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    obsQ.delete();
    obsRdyQ.delete();
    for (int i = 0; i < 6; i++) begin
      din_vld = 1'b1;
      din     = DW'(i + 200);
      step();
    end
    din_vld = 1'b0;
    step();
    checkOutput("abort no output", obsQ.size(), 0);
    checkOutput("abort bsy", bsy, 0);
    applyStimulus(0, 0, 1'b0);
    checkFrame('{5, 7, 13, 15});

    // Reset mid-frame with a stray start pulse inside the run.
    strt = 1'b1;
    step();
    strt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din_vld = 1'b1;
      din     = DW'(i + 300);
      if (i == 2) strt = 1'b1;
      step();
      strt = 1'b0;
    end
    din_vld = 1'b0;
    rst = 1'b1;
    step();
    checkOutput("midrst bsy", bsy, 0);
    checkOutput("midrst dout", $signed(dout), 0);
    rst = 1'b0;
    step();
    applyStimulus(0, 0, 1'b0);
    checkFrame('{5, 7, 13, 15});

    for (int f = 0; f < 8; f++) begin
      applyStimulus(2, 2, f[0]);
      checkOutput("rand out count", obsQ.size(), 4);
    end

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
